// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
package mem_arb_pkg;

   // Access sequencer states; grants are only decided in IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR     = 2'd1,
      RD     = 2'd2,
      RD_ACK = 2'd3
   } arbState_e;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between the write and read requesters, with a bounded
// write burst so a pending read cannot be starved forever.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int WR_BURST_MAX = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rdReq,
   input  logic      wrReq,
   input  logic      wrLock,
   input  arbState_e state,
   output logic      grantRd,
   output logic      grantWr
);

   localparam int CNT_W = (WR_BURST_MAX > 0) ? $clog2(WR_BURST_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(WR_BURST_MAX);

   logic [CNT_W-1:0] burstCnt;
   logic             effRd;

   assign effRd = rdReq & ~wrLock;

   // Pick at most one winner, and only while the sequencer is idle.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      grantRd = 1'b0;
      grantWr = 1'b0;
      if (state == IDLE) begin
         if (wrReq && effRd) begin
            if (burstCnt < BURST_MAX) grantWr = 1'b1;
            else                      grantRd = 1'b1;
         end else if (wrReq) begin
            grantWr = 1'b1;
         end else if (effRd) begin
            grantRd = 1'b1;
         end
      end
   end

   // Count writes granted while a read waits; any read grant restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         burstCnt <= '0;
      end else if (grantRd) begin
         burstCnt <= '0;
      end else if (grantWr && !wrLock) begin
         if (!rdReq)                    burstCnt <= '0;
         else if (burstCnt < BURST_MAX) burstCnt <= burstCnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences CPU reads and programmer writes onto one single-port memory.
// All outputs are registered; the priority decision lives in mem_arb_prio.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RD_LAT       = 1,
   parameter int WR_BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdReq,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData,
   output logic              rdValid,
   input  logic              wrReq,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   output logic              wrAck,
   input  logic              wrLock,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memDataRd,
   output logic [DATA_W-1:0] memDataWr,
   output logic              memWrEn,
   output logic              busy
);

   localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

   arbState_e        state;
   arbState_e        nextState;
   logic [LAT_W-1:0] latCnt;
   logic             grantRd;
   logic             grantWr;

   mem_arb_prio #(
      .WR_BURST_MAX(WR_BURST_MAX)
   ) uPrio (
      .clk    (clk),
      .rst    (rst),
      .rdReq  (rdReq),
      .wrReq  (wrReq),
      .wrLock (wrLock),
      .state  (state),
      .grantRd(grantRd),
      .grantWr(grantWr)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state: a write is one cycle, a read waits out the memory latency then acks.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (grantWr)      nextState = WR;
            else if (grantRd) nextState = RD;
         end
         WR:      nextState = IDLE;
         RD:      if (latCnt == '0) nextState = RD_ACK;
         RD_ACK:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Datapath and handshake registers; address/write data hold their last value when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         memAddr   <= '0;
         memDataWr <= '0;
         memWrEn   <= 1'b0;
         rdData    <= '0;
         rdValid   <= 1'b0;
         wrAck     <= 1'b0;
         busy      <= 1'b0;
         latCnt    <= '0;
      end else begin
         memWrEn <= 1'b0;
         rdValid <= 1'b0;
         wrAck   <= 1'b0;
         busy    <= (nextState != IDLE);
         case (state)
            IDLE: begin
               if (grantWr) begin
                  memAddr   <= wrAddr;
                  memDataWr <= wrData;
                  memWrEn   <= 1'b1;
                  wrAck     <= 1'b1;
               end else if (grantRd) begin
                  memAddr <= rdAddr;
                  latCnt  <= LAT_LOAD;
               end
            end
            RD: begin
               if (latCnt == '0) begin
                  rdData  <= memDataRd;
                  rdValid <= 1'b1;
               end else begin
                  latCnt <= latCnt - LAT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
